// File: rtl/failsafe_ctrl.sv
// rtl/failsafe_ctrl.sv - link-loss failsafe: arm, timeout, thrust ramp-down, latch
module failsafe_ctrl #(
    parameter int         FAST_SIM  = 1,
    parameter logic [8:0] RAMP_STEP = 9'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_rdy,
    input  logic       vld,
    input  logic [8:0] thrst_in,
    input  logic       motors_off_in,
    input  logic       clr_fs,
    output logic [8:0] thrst_out,
    output logic       motors_off_out,
    output logic       lvl,
    output logic       failsafe,
    output logic [1:0] state
);

    localparam int TW = (FAST_SIM != 0) ? 10 : 26;

    typedef enum logic [1:0] {
        S_DISARMED = 2'd0,
        S_ARMED    = 2'd1,
        S_RAMP     = 2'd2,
        S_LATCHED  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [8:0]      ramp_q, ramp_d;
    logic            cmd_rdy_q;
    logic            cmd_edge;
    logic            timer_tc;
    logic [8:0]      thrst_d;
    logic            motors_off_d;
    logic            lvl_d;
    logic            failsafe_d;

    assign cmd_edge = cmd_rdy & ~cmd_rdy_q;
    assign timer_tc = &timer_q;
    assign state    = state_q;

    // Link-silence timer: runs only while ARMED, restarted by any link activity, sticks at terminal count
    always_comb begin
        timer_d = timer_q;
        if (cmd_edge || (state_q != S_ARMED)) begin
            timer_d = '0;
        end else if (!timer_tc) begin
            timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
        end
    end

    // Mode transitions and ramp register; link activity wins over a same-cycle timeout
    always_comb begin
        state_d = state_q;
        ramp_d  = ramp_q;
        case (state_q)
            S_DISARMED: begin
                if (!motors_off_in) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (motors_off_in) begin
                    state_d = S_DISARMED;
                end else if (timer_tc && !cmd_edge) begin
                    state_d = S_RAMP;
                    ramp_d  = thrst_in;
                end
            end
            S_RAMP: begin
                if (motors_off_in || (ramp_q == 9'd0)) begin
                    state_d = S_LATCHED;
                end else if (vld) begin
                    ramp_d = (ramp_q > RAMP_STEP) ? (ramp_q - RAMP_STEP) : 9'd0;
                end
            end
            S_LATCHED: begin
                if (clr_fs && motors_off_in) begin
                    state_d = S_DISARMED;
                end
            end
            default: begin
                state_d = S_LATCHED;
            end
        endcase
    end

    // Output values for the state being entered, so outputs and state register move together
    always_comb begin
        thrst_d      = 9'd0;
        motors_off_d = 1'b1;
        lvl_d        = 1'b0;
        failsafe_d   = 1'b0;
        case (state_d)
            S_DISARMED: begin
                thrst_d      = 9'd0;
                motors_off_d = 1'b1;
            end
            S_ARMED: begin
                thrst_d      = thrst_in;
                motors_off_d = 1'b0;
            end
            S_RAMP: begin
                thrst_d      = ramp_d;
                motors_off_d = 1'b0;
                lvl_d        = 1'b1;
                failsafe_d   = 1'b1;
            end
            default: begin
                thrst_d      = 9'd0;
                motors_off_d = 1'b1;
                failsafe_d   = 1'b1;
            end
        endcase
    end

    // State, timer, ramp, link sampler and registered outputs; reset overrides every input
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_DISARMED;
            timer_q        <= '0;
            ramp_q         <= 9'd0;
            cmd_rdy_q      <= 1'b0;
            thrst_out      <= 9'd0;
            motors_off_out <= 1'b1;
            lvl            <= 1'b0;
            failsafe       <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            ramp_q         <= ramp_d;
            cmd_rdy_q      <= cmd_rdy;
            thrst_out      <= thrst_d;
            motors_off_out <= motors_off_d;
            lvl            <= lvl_d;
            failsafe       <= failsafe_d;
        end
    end

endmodule

// File: tb/tb_failsafe_ctrl.sv
// tb/tb_failsafe_ctrl.sv - randomized and directed checks of failsafe_ctrl against a behavioural model
module tb_failsafe_ctrl;

    localparam int TMAX = 1023;
    localparam int STEP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_rdy;
    logic       vld;
    logic [8:0] thrst_in;
    logic       motors_off_in;
    logic       clr_fs;
    logic [8:0] thrst_out;
    logic       motors_off_out;
    logic       lvl;
    logic       failsafe;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // model state: 0 disarmed, 1 armed, 2 ramp, 3 latched
    int m_state = 0;
    int m_timer = 0;
    int m_ramp  = 0;
    bit m_cmd   = 1'b0;
    int e_thr   = 0;
    int e_moff  = 1;
    int e_lvl   = 0;
    int e_fs    = 0;

    always #10 clk = ~clk;

    failsafe_ctrl #(.FAST_SIM(1), .RAMP_STEP(9'd4)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_rdy        (cmd_rdy),
        .vld            (vld),
        .thrst_in       (thrst_in),
        .motors_off_in  (motors_off_in),
        .clr_fs         (clr_fs),
        .thrst_out      (thrst_out),
        .motors_off_out (motors_off_out),
        .lvl            (lvl),
        .failsafe       (failsafe),
        .state          (state)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // behavioural reference: apply the mode rules to the inputs seen at each rising edge
    always @(posedge clk) begin
        int nxt;
        bit rise;
        if (rst) begin
            m_state = 0;
            m_timer = 0;
            m_ramp  = 0;
            m_cmd   = 1'b0;
        end else begin
            rise = cmd_rdy && !m_cmd;
            nxt  = m_state;
            if (m_state == 0) begin
                if (!motors_off_in) nxt = 1;
            end else if (m_state == 1) begin
                if (motors_off_in) nxt = 0;
                else if (m_timer == TMAX && !rise) begin
                    nxt    = 2;
                    m_ramp = int'(thrst_in);
                end
            end else if (m_state == 2) begin
                if (motors_off_in || m_ramp == 0) nxt = 3;
                else if (vld) begin
                    m_ramp = m_ramp - STEP;
                    if (m_ramp < 0) m_ramp = 0;
                end
            end else begin
                if (clr_fs && motors_off_in) nxt = 0;
            end
            if (m_state == 1 && !rise) m_timer = (m_timer < TMAX) ? m_timer + 1 : TMAX;
            else m_timer = 0;
            m_state = nxt;
            m_cmd   = cmd_rdy;
        end
        e_thr  = (m_state == 1) ? int'(thrst_in) : (m_state == 2) ? m_ramp : 0;
        e_moff = (m_state == 0 || m_state == 3) ? 1 : 0;
        e_lvl  = (m_state == 2) ? 1 : 0;
        e_fs   = (m_state >= 2) ? 1 : 0;
    end

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", int'(state), m_state);
            chk("thrst_out", int'(thrst_out), e_thr);
            chk("motors_off_out", int'(motors_off_out), e_moff);
            chk("lvl", int'(lvl), e_lvl);
            chk("failsafe", int'(failsafe), e_fs);
        end
    end

    initial begin
        int left;
        rst = 1'b1; cmd_rdy = 1'b0; vld = 1'b0; thrst_in = 9'd0;
        motors_off_in = 1'b1; clr_fs = 1'b0;
        cyc(2);
        chk_en = 1'b1;
        chk("reset_state", int'(state), 0);
        chk("reset_moff", int'(motors_off_out), 1);
        chk("reset_thr", int'(thrst_out), 0);
        chk("reset_fs", int'(failsafe), 0);
        rst = 1'b0;

        // arm at 200, time out, ramp down over 50 samples, latch
        thrst_in = 9'd200; motors_off_in = 1'b0;
        cyc(1);
        chk("arm_state", int'(state), 1);
        chk("arm_thr", int'(thrst_out), 200);
        cyc(1023);
        chk("pre_timeout_state", int'(state), 1);
        cyc(1);
        chk("timeout_state", int'(state), 2);
        chk("timeout_lvl", int'(lvl), 1);
        chk("timeout_fs", int'(failsafe), 1);
        chk("timeout_thr", int'(thrst_out), 200);
        for (int i = 0; i < 50; i++) begin
            vld = 1'b1; cyc(1); vld = 1'b0;
            if (i == 48) chk("ramp_49", int'(thrst_out), 4);
            if (i < 49) cyc(1);
        end
        chk("ramp_50_thr", int'(thrst_out), 0);
        chk("ramp_50_state", int'(state), 2);
        cyc(1);
        chk("latch_state", int'(state), 3);
        chk("latch_moff", int'(motors_off_out), 1);

        // stale clear ignored, valid clear disarms
        clr_fs = 1'b1; cyc(1); clr_fs = 1'b0;
        chk("stale_clr", int'(state), 3);
        motors_off_in = 1'b1; clr_fs = 1'b1; cyc(1); clr_fs = 1'b0;
        chk("clr_disarm", int'(state), 0);

        // link edge in the terminal-count cycle restarts the timer
        thrst_in = 9'd100; motors_off_in = 1'b0;
        cyc(1);
        cyc(1023);
        chk("tc_armed", int'(state), 1);
        cmd_rdy = 1'b1; cyc(1); cmd_rdy = 1'b0;
        chk("tc_edge_wins", int'(state), 1);
        cyc(1023);
        chk("tc_restart_armed", int'(state), 1);
        cyc(1);
        chk("tc_restart_ramp", int'(state), 2);
        motors_off_in = 1'b1; cyc(1);
        chk("ramp_moff_latch", int'(state), 3);
        clr_fs = 1'b1; cyc(1); clr_fs = 1'b0;

        // ramp from 6: entry-cycle sample ignored, 6 -> 2 -> 0 without wrap
        thrst_in = 9'd6; motors_off_in = 1'b0;
        cyc(1024);
        vld = 1'b1; cyc(1); vld = 1'b0;
        chk("six_entry_state", int'(state), 2);
        chk("six_entry_thr", int'(thrst_out), 6);
        vld = 1'b1; cyc(1); vld = 1'b0;
        chk("six_to_two", int'(thrst_out), 2);
        vld = 1'b1; cyc(1); vld = 1'b0;
        chk("two_to_zero", int'(thrst_out), 0);
        cyc(1);
        chk("six_latched", int'(state), 3);
        motors_off_in = 1'b1; clr_fs = 1'b1; cyc(1); clr_fs = 1'b0;

        // zero-thrust timeout latches on the following clock
        thrst_in = 9'd0; motors_off_in = 1'b0;
        cyc(1025);
        chk("zero_ramp", int'(state), 2);
        cyc(1);
        chk("zero_latched", int'(state), 3);
        motors_off_in = 1'b1; clr_fs = 1'b1; cyc(1); clr_fs = 1'b0;

        // reset mid-ramp at 120
        thrst_in = 9'd200; motors_off_in = 1'b0;
        cyc(1025);
        for (int i = 0; i < 20; i++) begin
            vld = 1'b1; cyc(1); vld = 1'b0; cyc(1);
        end
        chk("ramp_120", int'(thrst_out), 120);
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("rst_state", int'(state), 0);
        chk("rst_thr", int'(thrst_out), 0);
        chk("rst_moff", int'(motors_off_out), 1);
        chk("rst_fs", int'(failsafe), 0);

        // periodic link activity keeps the vehicle armed
        thrst_in = 9'd50;
        cyc(1);
        left = 0;
        for (int i = 0; i < 10000; i++) begin
            cmd_rdy = ((i % 900) == 0);
            cyc(1);
            if (state != 2'd1 || failsafe) left++;
        end
        cmd_rdy = 1'b0;
        chk("link_hold", left, 0);

        // randomized traffic against the model
        for (int i = 0; i < 6000; i++) begin
            rst     = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 1499) == 0) motors_off_in = ~motors_off_in;
            if ($urandom_range(0, 19) == 0) thrst_in = 9'($urandom_range(0, 511));
            vld     = ($urandom_range(0, 2) == 0);
            clr_fs  = ($urandom_range(0, 9) == 0);
            cmd_rdy = ($urandom_range(0, 1499) == 0);
            cyc(1);
        end
        rst = 1'b0; vld = 1'b0; clr_fs = 1'b0; cmd_rdy = 1'b0;
        cyc(1);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
